// File: rtl/code_lock_ctrl.sv
// Multi-digit combination lock: debounced confirm/save buttons, code compare,
// reprogramming while open, timed lockout after repeated failures, RGB status LED.

module code_lock_deb #(
  parameter int DEB_CYCLES = 240_000
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic pulse
);
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          deb;

  // sync[0]/sync[1] differing means the synced level is about to change
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync  <= 2'b11;
      cnt   <= '0;
      deb   <= 1'b1;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[0], pin};
      pulse <= 1'b0;
      if (sync[0] != sync[1])
        cnt <= '0;
      else if (cnt != CW'(DEB_CYCLES - 1))
        cnt <= cnt + 1'b1;
      else begin
        deb   <= sync[1];
        pulse <= deb & ~sync[1];
      end
    end
  end
endmodule

module code_lock_ctrl #(
  parameter int                  W           = 4,
  parameter int                  DIGITS      = 4,
  parameter logic [DIGITS*W-1:0] INIT_CODE   = {DIGITS{4'hC}},
  parameter int                  MAX_FAIL    = 3,
  parameter int                  LOCK_CYCLES = 36_000_000,
  parameter int                  DEB_CYCLES  = 240_000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [W-1:0]                  sw,
  input  logic                          confirm,
  input  logic                          save,
  output logic [2:0]                    led,
  output logic                          locked_out,
  output logic [$clog2(DIGITS+1)-1:0]   digit_cnt
);
  localparam int NUM_BTN = 2;
  localparam int EW      = DIGITS * W;
  localparam int DCW     = $clog2(DIGITS + 1);
  localparam int FCW     = $clog2(MAX_FAIL + 1);
  localparam int TW      = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_ENTRY, S_OPEN, S_FAIL, S_LOCKOUT, S_PROG} state_t;

  logic [NUM_BTN-1:0] btn_raw, btn_pulse;
  logic               cp, sp;
  logic [1:0][W-1:0]  sw_sync;

  state_t          state, state_n;
  logic [EW-1:0]   entry, entry_n, code, code_n, shifted, sw_ext;
  logic [DCW-1:0]  dcnt, dcnt_n, dcnt_inc;
  logic [FCW-1:0]  fails, fails_n, fails_inc;
  logic [TW-1:0]   timer, timer_n;
  logic            last_digit;

  assign btn_raw = {save, confirm};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_deb
    code_lock_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .pin   (btn_raw[i]),
      .pulse (btn_pulse[i])
    );
  end

  assign cp = btn_pulse[0];
  assign sp = btn_pulse[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sw_sync <= '0;
    else      sw_sync <= {sw_sync[0], sw};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      entry <= '0;
      code  <= INIT_CODE;
      dcnt  <= '0;
      fails <= '0;
      timer <= '0;
    end else begin
      state <= state_n;
      entry <= entry_n;
      code  <= code_n;
      dcnt  <= dcnt_n;
      fails <= fails_n;
      timer <= timer_n;
    end
  end

  always_comb begin
    sw_ext          = '0;
    sw_ext[W-1:0]   = sw_sync[1];
    shifted         = (entry << W) | sw_ext;
    dcnt_inc        = dcnt + 1'b1;
    last_digit      = (dcnt_inc == DCW'(DIGITS));
    fails_inc       = (fails == FCW'(MAX_FAIL)) ? fails : fails + 1'b1;
    state_n         = state;
    entry_n         = entry;
    code_n          = code;
    dcnt_n          = dcnt;
    fails_n         = fails;
    timer_n         = timer;
    unique case (state)
      // IDLE holds a cleared register and zero count, so it shares the ENTRY path
      S_IDLE, S_ENTRY: if (cp) begin
        entry_n = shifted;
        dcnt_n  = dcnt_inc;
        state_n = S_ENTRY;
        if (last_digit) begin
          if (shifted == code) begin
            state_n = S_OPEN;
            fails_n = '0;
          end else begin
            fails_n = fails_inc;
            if (fails_inc >= FCW'(MAX_FAIL)) begin
              state_n = S_LOCKOUT;
              timer_n = TW'(LOCK_CYCLES);
            end else begin
              state_n = S_FAIL;
            end
          end
        end
      end
      S_OPEN: begin
        if (sp) begin
          state_n = S_PROG;
          entry_n = '0;
          dcnt_n  = '0;
        end else if (cp) begin
          state_n = S_IDLE;
          entry_n = '0;
          dcnt_n  = '0;
        end
      end
      S_FAIL: if (cp) begin
        state_n = S_IDLE;
        entry_n = '0;
        dcnt_n  = '0;
      end
      S_LOCKOUT: begin
        if (timer <= TW'(1)) begin
          state_n = S_IDLE;
          timer_n = '0;
          fails_n = '0;
          entry_n = '0;
          dcnt_n  = '0;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      S_PROG: if (cp) begin
        entry_n = shifted;
        dcnt_n  = dcnt_inc;
        if (last_digit) begin
          code_n  = shifted;
          state_n = S_IDLE;
          entry_n = '0;
          dcnt_n  = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    led = 3'b111;
    unique case (state)
      S_OPEN:    led = 3'b101;
      S_FAIL:    led = 3'b011;
      S_LOCKOUT: led = 3'b010;
      S_PROG:    led = 3'b110;
      default:   led = 3'b111;
    endcase
  end

  assign locked_out = (state == S_LOCKOUT);
  assign digit_cnt  = dcnt;
endmodule

// File: tb/tb_code_lock_ctrl.sv
// Bench for code_lock_ctrl: directed test-plan sequences plus randomized button/switch
// activity, all checked each cycle against a digit-queue model of the lock.

module tb_code_lock_ctrl;
  localparam int W = 4, DIGITS = 2, MAX_FAIL = 3, LOCK_CYCLES = 100, DEB_CYCLES = 4;
  localparam logic [7:0] INIT_CODE = 8'hC3;
  localparam int DCW = $clog2(DIGITS + 1);
  localparam int M_IDLE = 0, M_ENTRY = 1, M_OPEN = 2, M_FAIL = 3, M_LOCK = 4, M_PROG = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [W-1:0]   sw = '0;
  logic           confirm = 1'b1;
  logic           save = 1'b1;
  logic [2:0]     led;
  logic           locked_out;
  logic [DCW-1:0] digit_cnt;

  code_lock_ctrl #(
    .W(W), .DIGITS(DIGITS), .INIT_CODE(INIT_CODE), .MAX_FAIL(MAX_FAIL),
    .LOCK_CYCLES(LOCK_CYCLES), .DEB_CYCLES(DEB_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .sw(sw), .confirm(confirm), .save(save),
    .led(led), .locked_out(locked_out), .digit_cnt(digit_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int lo_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_mode, m_fails, m_lock_left, m_swq1, m_swq2;
  int m_entry[$];
  int m_code[DIGITS];
  bit hist_c[$], hist_s[$];
  bit m_deb_c, m_deb_s, m_cp, m_sp;

  function automatic bit all_eq(input bit q[$], input bit v);
    if (q.size() != DEB_CYCLES + 1) return 1'b0;
    foreach (q[i]) if (q[i] != v) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [2:0] exp_led(input int m);
    case (m)
      M_OPEN:  return 3'b101;
      M_FAIL:  return 3'b011;
      M_LOCK:  return 3'b010;
      M_PROG:  return 3'b110;
      default: return 3'b111;
    endcase
  endfunction

  task automatic model_reset();
    int c;
    c = int'(INIT_CODE);
    m_mode = M_IDLE; m_fails = 0; m_lock_left = 0;
    m_entry.delete();
    for (int i = 0; i < DIGITS; i++) m_code[i] = (c >> (W * (DIGITS - 1 - i))) & 15;
    hist_c.delete(); hist_s.delete();
    for (int i = 0; i <= DEB_CYCLES; i++) begin hist_c.push_back(1'b1); hist_s.push_back(1'b1); end
    m_deb_c = 1'b1; m_deb_s = 1'b1; m_cp = 1'b0; m_sp = 1'b0;
    m_swq1 = 0; m_swq2 = 0;
  endtask

  task automatic model_step();
    int  d;
    bit  match;
    d = m_swq2;
    case (m_mode)
      M_IDLE, M_ENTRY: if (m_cp) begin
        m_entry.push_back(d);
        if (m_entry.size() == DIGITS) begin
          match = 1'b1;
          for (int i = 0; i < DIGITS; i++) if (m_entry[i] != m_code[i]) match = 1'b0;
          if (match) begin
            m_mode = M_OPEN; m_fails = 0;
          end else begin
            m_fails = (m_fails < MAX_FAIL) ? m_fails + 1 : MAX_FAIL;
            if (m_fails >= MAX_FAIL) begin m_mode = M_LOCK; m_lock_left = LOCK_CYCLES; end
            else m_mode = M_FAIL;
          end
        end else m_mode = M_ENTRY;
      end
      M_OPEN: begin
        if (m_sp)      begin m_mode = M_PROG; m_entry.delete(); end
        else if (m_cp) begin m_mode = M_IDLE; m_entry.delete(); end
      end
      M_FAIL: if (m_cp) begin m_mode = M_IDLE; m_entry.delete(); end
      M_LOCK: begin
        m_lock_left--;
        if (m_lock_left == 0) begin m_mode = M_IDLE; m_fails = 0; m_entry.delete(); end
      end
      M_PROG: if (m_cp) begin
        m_entry.push_back(d);
        if (m_entry.size() == DIGITS) begin
          for (int i = 0; i < DIGITS; i++) m_code[i] = m_entry[i];
          m_mode = M_IDLE; m_entry.delete();
        end
      end
      default: ;
    endcase
    // a press is accepted once DEB_CYCLES+1 consecutive pin samples agree
    m_cp = 1'b0; m_sp = 1'b0;
    if (m_deb_c && all_eq(hist_c, 1'b0))      begin m_cp = 1'b1; m_deb_c = 1'b0; end
    else if (!m_deb_c && all_eq(hist_c, 1'b1)) m_deb_c = 1'b1;
    if (m_deb_s && all_eq(hist_s, 1'b0))      begin m_sp = 1'b1; m_deb_s = 1'b0; end
    else if (!m_deb_s && all_eq(hist_s, 1'b1)) m_deb_s = 1'b1;
    hist_c.push_back(confirm); if (hist_c.size() > DEB_CYCLES + 1) void'(hist_c.pop_front());
    hist_s.push_back(save);    if (hist_s.size() > DEB_CYCLES + 1) void'(hist_s.pop_front());
    m_swq2 = m_swq1; m_swq1 = int'(sw);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else      model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    check("led", 32'(led), 32'(exp_led(m_mode)));
    check("locked_out", 32'(locked_out), 32'(m_mode == M_LOCK));
    check("digit_cnt", 32'(digit_cnt), 32'(m_entry.size()));
  end

  initial forever begin
    @(negedge clk);
    if (locked_out === 1'b1) lo_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input bit c, input bit s, input logic [W-1:0] d);
    sw = d; cyc(3);
    confirm = !c; save = !s; cyc(DEB_CYCLES + 4);
    confirm = 1'b1; save = 1'b1; cyc(DEB_CYCLES + 4);
  endtask

  task automatic entry2(input logic [W-1:0] a, input logic [W-1:0] b);
    press(1, 0, a); press(1, 0, b);
  endtask

  task automatic expect_out(input string tag, input logic [2:0] l, input logic lo, input int dc);
    @(negedge clk);
    check({tag, " led"}, 32'(led), 32'(l));
    check({tag, " locked_out"}, 32'(locked_out), 32'(lo));
    check({tag, " digit_cnt"}, 32'(digit_cnt), 32'(dc));
    @(posedge clk); #2;
  endtask

  function automatic logic [W-1:0] pick_sw();
    case ($urandom_range(0, 4))
      0:       return 4'hC;
      1:       return 4'h3;
      2:       return 4'h5;
      3:       return 4'hA;
      default: return W'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    int lo_base, hold_c, hold_s;
    cyc(2);
    expect_out("reset", 3'b111, 1'b0, 0);
    rst = 1'b1; cyc(2);

    press(1, 0, 4'hC);           expect_out("first digit", 3'b111, 1'b0, 1);
    press(1, 0, 4'h3);           expect_out("open", 3'b101, 1'b0, 2);
    press(1, 0, 4'h0);           expect_out("close", 3'b111, 1'b0, 0);

    entry2(4'h1, 4'h2);          expect_out("fail1", 3'b011, 1'b0, 2);
    press(1, 0, 4'h0);           expect_out("fail1 clear", 3'b111, 1'b0, 0);
    entry2(4'h1, 4'h2);          expect_out("fail2", 3'b011, 1'b0, 2);
    press(1, 0, 4'h0);
    lo_base = lo_cnt;
    entry2(4'h1, 4'h2);          expect_out("lockout", 3'b010, 1'b1, 2);
    press(1, 0, 4'h5);           expect_out("lockout cp ignored", 3'b010, 1'b1, 2);
    for (int i = 0; i < 200 && locked_out === 1'b1; i++) cyc(1);
    expect_out("after lockout", 3'b111, 1'b0, 0);
    check("lockout length", 32'(lo_cnt - lo_base), 32'(LOCK_CYCLES));

    sw = 4'hC; cyc(3);
    confirm = 1'b0; cyc(2); confirm = 1'b1; cyc(1); confirm = 1'b0; cyc(10);
    confirm = 1'b1; cyc(DEB_CYCLES + 4);
    expect_out("bounce", 3'b111, 1'b0, 1);
    press(1, 0, 4'h3);           expect_out("open2", 3'b101, 1'b0, 2);

    press(0, 1, 4'h0);           expect_out("prog", 3'b110, 1'b0, 0);
    press(1, 0, 4'h5);           expect_out("prog d1", 3'b110, 1'b0, 1);
    press(1, 0, 4'hA);           expect_out("prog done", 3'b111, 1'b0, 0);
    entry2(4'hC, 4'h3);          expect_out("old code", 3'b011, 1'b0, 2);
    press(1, 0, 4'h0);
    entry2(4'h5, 4'hA);          expect_out("new code", 3'b101, 1'b0, 2);

    press(1, 0, 4'h0);
    press(0, 1, 4'h0);           expect_out("sp idle", 3'b111, 1'b0, 0);
    press(1, 0, 4'h5);
    press(0, 1, 4'h0);           expect_out("sp entry", 3'b111, 1'b0, 1);
    press(1, 0, 4'hA);           expect_out("open3", 3'b101, 1'b0, 2);
    press(1, 1, 4'h0);           expect_out("cp+sp open", 3'b110, 1'b0, 0);

    press(1, 0, 4'h7);           expect_out("prog partial", 3'b110, 1'b0, 1);
    rst = 1'b0; cyc(2);          expect_out("reset mid prog", 3'b111, 1'b0, 0);
    rst = 1'b1; cyc(2);
    entry2(4'hC, 4'h3);          expect_out("init code back", 3'b101, 1'b0, 2);
    press(1, 0, 4'h0);

    hold_c = 0; hold_s = 0;
    for (int t = 0; t < 3000; t++) begin
      if (hold_c == 0) begin confirm = 1'($urandom_range(0, 1)); hold_c = $urandom_range(1, 12); end
      if (hold_s == 0) begin save = ($urandom_range(0, 3) != 0); hold_s = $urandom_range(1, 12); end
      hold_c--; hold_s--;
      if ($urandom_range(0, 3) == 0) sw = pick_sw();
      if ($urandom_range(0, 1499) == 0) begin rst = 1'b0; cyc(2); rst = 1'b1; end
      cyc(1);
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/code_lock_ctrl.md
# code_lock_ctrl

Parametrised multi-digit combination lock for the board's switch/button front panel. Active-low `confirm` and `save` buttons are debounced internally. Each `confirm` press latches one `sw` digit. After `DIGITS` digits the entry is compared with the stored code, which can be reprogrammed only while the lock is open. Consecutive failures trigger a timed lockout. Drives the active-low RGB LED directly.

## Interface
- `W`, 4: bits per digit (`sw` width)
- `DIGITS`, 4: digits per code, ≥1
- `INIT_CODE`, `{DIGITS{4'hC}}`: code after reset; digit 0 in the MS W bits
- `MAX_FAIL`, 3: consecutive failures that trigger lockout, ≥1
- `LOCK_CYCLES`, 36_000_000: lockout duration in clk cycles (3 s @ 12 MHz)
- `DEB_CYCLES`, 240_000: stable-low time to accept a press (20 ms)
- `clk` in 1: 12 MHz system clock
- `rst` in 1: reset, asynchronous, active-low
- `sw` in W: digit value, asynchronous to clk, sampled through a 2-FF synchroniser
- `confirm` in 1: button, active-low, raw/bouncy
- `save` in 1: button, active-low, raw/bouncy
- `led` out 3: {red, green, blue}, active-low
- `locked_out` out 1: high during LOCKOUT
- `digit_cnt` out clog2(DIGITS+1): digits entered so far

## Operation
- **Debounce (per button):**
  - 2-FF synchroniser feeds a stable counter, which restarts on any change of the synced level.
  - When the counter reaches DEB_CYCLES−1 with the level unchanged, the debounced level updates.
  - A one-cycle pulse fires on a debounced 1→0 transition. Release produces no pulse.
- **States:** IDLE, ENTRY, OPEN, FAIL, LOCKOUT, PROG. LED per state:
  - IDLE 111, ENTRY 111, OPEN 101 (green), FAIL 011 (red), LOCKOUT 010 (red+blue), PROG 110 (blue)
- **Entry shift register:**
  - DIGITS×W bits; on each accepted digit it shifts left by W and inserts synced `sw`.
  - Cleared whenever IDLE is entered.
- **Transitions on `confirm` pulse (cp):**
  - IDLE: capture digit, `digit_cnt`=1, go to ENTRY. If DIGITS=1, compare immediately.
  - ENTRY: capture digit and increment. When `digit_cnt` reaches DIGITS, compare the full register with the code; nothing is revealed before that.
  - On match: go to OPEN and clear the fail counter.
  - On mismatch: increment the fail counter (saturating). If the counter reaches MAX_FAIL, go to LOCKOUT and load the lock timer; otherwise go to FAIL.
  - OPEN or FAIL: go to IDLE; no digit is captured.
  - LOCKOUT: cp is ignored.
  - PROG: capture digit. After the DIGITS-th digit, write the register to the code and go to IDLE.
- **`save` pulse (sp):**
  - Honoured only in OPEN: go to PROG with `digit_cnt`=0. Ignored in every other state.
  - If cp and sp arrive in the same cycle in OPEN, sp wins. In any other state, cp is processed and sp is dropped.
- **LOCKOUT:**
  - The timer counts down each cycle. On reaching 0, go to IDLE, clear the fail counter, and drop `locked_out`.
- **Reset behaviour:**
  - Any state, including mid-PROG, goes to IDLE.
  - Code returns to INIT_CODE. A partial PROG entry is discarded.

## Timing
- **Reset values:** `led`=111, `locked_out`=0, `digit_cnt`=0, state IDLE, fail counter 0, debounced levels 1, no pulses.
- **Press latency:** the pulse fires DEB_CYCLES+2 (±1) cycles after the pin goes stably low.
- **State latency:** state and `led` change on the clk edge after the pulse cycle.
- **Compare timing:** compare happens in the same cycle as the last digit capture, so OPEN/FAIL/LOCKOUT appear one cycle after the final pulse.
- **`sw` sampling:** `sw` must be stable ≥3 cycles before the pulse.
- **Bounce rejection:** bounces shorter than DEB_CYCLES produce no pulse.
- **`digit_cnt` width:** clog2(DIGITS+1); it never exceeds DIGITS.
- **Lock timer:** width clog2(LOCK_CYCLES+1); LOCKOUT lasts exactly LOCK_CYCLES cycles.

## Test plan
Bench parameters: W=4, DIGITS=2, INIT_CODE=8'hC3, MAX_FAIL=3, LOCK_CYCLES=100, DEB_CYCLES=4.
- Enter C then 3 -> `led`=101 one cycle after the 2nd pulse; further cp -> `led`=111, `digit_cnt`=0.
- Three wrong entries (1,2) -> 011, 011, then `led`=010 with `locked_out`=1 for 100 cycles; cp during lockout is ignored; afterwards IDLE with `led`=111.
- Bounce: pin low for 2 cycles, high, then low for 10 -> exactly one pulse and one digit captured.
- Open, sp, enter 5,A -> `led` 110 then 111. Entering C,3 now gives 011; entering 5,A gives 101.
- sp while in IDLE or ENTRY -> ignored. cp and sp in the same cycle in OPEN -> PROG.
- Reset asserted mid-PROG after 1 digit -> `led`=111, `digit_cnt`=0; code is C3 again.
